// File: rtl/spi_peripheral_responder_pkg.sv
// Shared state type and default sizing for the SPI peripheral responder.
// Imported by the interface, the synchroniser and the top.
package spi_pkg;

    localparam int unsigned SPI_WIDTH       = 8;
    localparam int unsigned SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } spi_rsp_state_t;

endpackage

// File: rtl/spi_peripheral_responder_if.sv
// Pin and CPU-side bundle of the SPI responder; slave = responder, master = controller/CPU side.
// overrun exists only when SPI_RESPONDER_OVERRUN_EN is defined.
interface spi_peripheral_responder_if
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH
);
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic             miso_oe;
    logic [WIDTH-1:0] data_miso;
    logic             dv_miso;
    logic [WIDTH-1:0] data_mosi;
    logic             dv_mosi;
    logic             rx_full;
    logic             control_rd;
`ifdef SPI_RESPONDER_OVERRUN_EN
    logic             overrun;
`endif

    modport slave (
        input  sclk, cs_n, mosi, data_miso, dv_miso, control_rd,
        output miso, miso_oe, data_mosi, dv_mosi, rx_full
`ifdef SPI_RESPONDER_OVERRUN_EN
        , output overrun
`endif
    );

    modport master (
        output sclk, cs_n, mosi, data_miso, dv_miso, control_rd,
        input  miso, miso_oe, data_mosi, dv_mosi, rx_full
`ifdef SPI_RESPONDER_OVERRUN_EN
        , input overrun
`endif
    );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with rise/fall pulses taken from the
// synchronised output and one further delayed copy.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES,
    parameter bit          RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral_responder.sv
// SPI mode-0 responder: oversampled pins, full-duplex MSB-first shifting, CPU word handshake.
// Define SPI_RESPONDER_OVERRUN_EN to add the sticky overrun flag.
module spi_peripheral_responder
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH       = SPI_WIDTH,
    parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
    input logic                       clk,
    input logic                       rst_n,
    spi_peripheral_responder_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    spi_rsp_state_t         state_q, state_d;
    logic [WIDTH-1:0]       tx_q, tx_d;
    logic [WIDTH-1:0]       shadow_q, load_val;
    logic [WIDTH-1:0]       data_mosi_q, data_mosi_d;
    logic [WIDTH-1:0]       rx_word;
    logic [WIDTH-2:0]       rx_q, rx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   rx_full_q, rx_full_d;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   mosi_s, miso;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b0)
    ) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b1)
    ) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (bus.cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    // A strobe in the LOAD/DONE cycle bypasses the shadow; otherwise the last byte repeats.
    assign load_val = bus.dv_miso ? bus.data_miso : shadow_q;
    assign rx_word  = {rx_q, mosi_s};

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        data_mosi_d = data_mosi_q;
        unique case (state_q)
            IDLE: begin
                if (cs_fall) state_d = LOAD;
            end
            LOAD, DONE: begin
                tx_d    = load_val;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_d  = rx_word[WIDTH-2:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        data_mosi_d = rx_word;
                        state_d     = DONE;
                    end
                end else if (sclk_fall && cnt_q != '0) begin
                    // With cnt at 0 the fall closes the previous word; keep the fresh MSB.
                    tx_d = {tx_q[WIDTH-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
        if (cs_rise && state_q != IDLE) begin
            state_d     = IDLE;
            data_mosi_d = data_mosi_q;
        end
    end

    always_comb begin
        rx_full_d = rx_full_q;
        if (bus.control_rd) rx_full_d = 1'b0;
        if (state_q == DONE) rx_full_d = 1'b1;
    end

    always_comb begin
        miso = 1'b0;
        case (state_q)
            LOAD, DONE: miso = load_val[WIDTH-1];
            SHIFT:      miso = tx_q[WIDTH-1];
            default:    miso = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            cnt_q       <= '0;
            shadow_q    <= '0;
            data_mosi_q <= '0;
            rx_full_q   <= 1'b0;
            mosi_q      <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            shadow_q    <= load_val;
            data_mosi_q <= data_mosi_d;
            rx_full_q   <= rx_full_d;
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
        end
    end

    assign bus.miso      = miso;
    assign bus.miso_oe   = (state_q != IDLE);
    assign bus.data_mosi = data_mosi_q;
    assign bus.dv_mosi   = (state_q == DONE);
    assign bus.rx_full   = rx_full_q | (state_q == DONE);

`ifdef SPI_RESPONDER_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (bus.control_rd) overrun_d = 1'b0;
        if (state_q == DONE && rx_full_q && !bus.control_rd) overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) overrun_q <= 1'b0;
        else        overrun_q <= overrun_d;
    end

    assign bus.overrun = overrun_q;
`endif

endmodule

// File: doc/spi_peripheral_responder.md
Name: spi_peripheral_responder

Overview:
- SPI mode-0 peripheral (responder) end of the CPU SPI link; answers the controller that drives sclk/cs_n/mosi.
- Oversamples the serial pins on the system clock, deserialises MOSI bytes to a parallel register, and serialises a CPU-loaded byte back on MISO.
- Sits between the SPI pins and the CPU register file; full-duplex, MSB first, multiple bytes per cs_n assertion.

Parameters:
- WIDTH, 8, bits per SPI word.
- SYNC_STAGES, 2, flip-flop stages on sclk, cs_n and mosi inputs (min 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- sclk  in  1  SPI clock from controller, asynchronous.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  serial data from controller.
- miso  out  1  serial data to controller.
- miso_oe  out  1  MISO output enable; high only while selected.
- data_miso  in  WIDTH  byte to transmit on the next word.
- dv_miso  in  1  one-cycle strobe; captures data_miso into the TX shadow.
- data_mosi  out  WIDTH  last fully received word.
- dv_mosi  out  1  one-cycle pulse when data_mosi updates.
- rx_full  out  1  unread word held in data_mosi.
- control_rd  in  1  CPU read acknowledge; clears rx_full.

Behaviour:
- Reset (rst_n low at a clk edge) clears all of the following, whatever the state or partial byte: data_mosi=0, dv_mosi=0, rx_full=0, miso=0, miso_oe=0, TX shadow=0, bit counter=0. State goes to IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected from the last two synchronised samples. sclk must be at most clk/8.
- State IDLE: miso_oe=0, miso=0. When synchronised cs_n falls, go to LOAD.
- State LOAD, one cycle: shift register takes the TX shadow; miso drives the MSB; miso_oe=1; bit counter=0. Then go to SHIFT.
- State SHIFT:
  - On a synchronised sclk rise, shift mosi into the RX shift register LSB and increment the counter.
  - On a synchronised sclk fall, shift the TX register left so miso shows the next bit.
  - When the counter reaches WIDTH on a rise, go to DONE.
- State DONE, one cycle:
  - data_mosi gets the RX shift value; dv_mosi=1; rx_full=1.
  - The TX shift register reloads from the shadow and the counter resets.
  - miso drives the new MSB.
  - Return to SHIFT for the next word of the same transaction.
- Latency:
  - dv_mosi rises SYNC_STAGES+1 clk cycles after the WIDTH-th sclk rising edge at the pin.
  - miso updates SYNC_STAGES+1 cycles after an sclk falling edge.
- cs_n rises in any state other than IDLE:
  - Go to IDLE next cycle. A partial word is discarded: no dv_mosi, data_mosi unchanged.
  - miso_oe drops.
- dv_miso in the same cycle as LOAD or DONE: the new data_miso bypasses the shadow and is loaded directly.
- If dv_miso does not arrive, the shadow keeps its value and the last byte is retransmitted.
- control_rd clears rx_full. If it coincides with DONE, DONE wins and rx_full=1.
- A word completing while rx_full=1 overwrites data_mosi (baseline).

Optional Feature:
- Macro: SPI_RESPONDER_OVERRUN_EN.
- Defined:
  - Adds output port overrun (1 bit, reset 0).
  - overrun is sticky. It is set in DONE when rx_full was already 1 and control_rd is not asserted in that cycle.
  - It is cleared by control_rd, unless DONE sets it in the same cycle (set wins).
  - data_mosi is still overwritten.
- Undefined: no port and no logic; overwrite is silent.

Decomposition:
- Shared package spi_pkg holds:
  - state enum spi_rsp_state_t {IDLE, LOAD, SHIFT, DONE};
  - constant SPI_WIDTH=8;
  - constant SPI_SYNC_STAGES=2.
- One natural sub-module, spi_sync_edge: a SYNC_STAGES synchroniser with rise/fall detect. Instantiate it for sclk and cs_n; use the synchroniser only for mosi.

Test Plan:
- Single byte: dv_miso with data_miso=8'hA5, then the controller sends 8'h3C (cs_n low, 8 sclk, clk/8) -> miso carries A5 MSB first; data_mosi=8'h3C; one dv_mosi pulse; rx_full=1.
- Two bytes, one cs_n: shadow 8'h5A, controller sends 8'h01, 8'h02 -> dv_mosi pulses twice; data_mosi ends 8'h02; miso returns 5A, then 5A again.
- Abort: cs_n rises after 5 sclk -> no dv_mosi; data_mosi unchanged; miso_oe=0 within SYNC_STAGES+2 cycles.
- Reset mid-word: rst_n low during bit 4 -> all outputs 0; the next full transaction 8'hFF is received correctly.
- Read ack: control_rd after byte 8'h81 -> rx_full 0. Control_rd coinciding with DONE -> rx_full stays 1.
- Overrun (macro defined): two bytes with no control_rd -> overrun=1 after the second; control_rd -> overrun=0. Macro undefined -> no port, and data_mosi holds the second byte.
